hdmi_audio_pacer: RTL and testbench

//  Parametrised successor to the fixed integer 48 kHz divider in the HDMI video top.

---
 rtl/audio_pkg.sv | 16 +
 rtl/audio_frame_fifo.sv | 70 +++++++
 rtl/hdmi_audio_pacer.sv | 111 +++++++++++
 tb/tb_hdmi_audio_pacer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared helpers for the HDMI audio pacer: frame/accumulator widths and saturating counters.
package audio_pkg;

    function automatic int unsigned frame_w(input int unsigned channels, input int unsigned width);
        return channels * width;
    endfunction

    function automatic int unsigned acc_width(input int unsigned clk_hz);
        return $clog2(clk_hz) + 2;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/audio_frame_fifo.sv
// Synchronous frame FIFO with a separate fill counter; refuses pushes when full and pops when empty.
module audio_frame_fifo
    import audio_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned DW    = 32
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  logic [DW-1:0]            push_data,
    input  logic                     pop,
    output logic [DW-1:0]            head_c,
    output logic [$clog2(DEPTH):0]   fill,
    output logic                     full_c,
    output logic                     empty_c
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned FW = PW + 1;

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [FW-1:0] fill_q, fill_d;
    logic          push_ok_c;
    logic          pop_ok_c;

    assign full_c  = (fill_q == FW'(DEPTH));
    assign empty_c = (fill_q == '0);
    assign head_c  = mem_q[rd_ptr_q];
    assign fill    = fill_q;

    always_comb begin
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        fill_d    = fill_q;
        push_ok_c = push && !full_c;
        pop_ok_c  = pop && !empty_c;
        if (push_ok_c) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop_ok_c) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        // Fill moves only when exactly one side acts.
        if (push_ok_c && !pop_ok_c) begin
            fill_d = fill_q + FW'(1);
        end else if (pop_ok_c && !push_ok_c) begin
            fill_d = fill_q - FW'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
        end
    end

endmodule

// File: rtl/hdmi_audio_pacer.sv
// Fractional-accumulator audio clock generator that paces buffered PCM frames into the HDMI encoder.
module hdmi_audio_pacer
    import audio_pkg::*;
#(
    parameter int unsigned CLK_HZ        = 32000000,
    parameter int unsigned RATE_HZ       = 48000,
    parameter int unsigned CHANNELS      = 2,
    parameter int unsigned WIDTH         = 16,
    parameter int unsigned DEPTH         = 4,
    parameter bit          MUTE_UNDERRUN = 1'b0
) (
    input  logic                                clk,
    input  logic                                resetn,
    input  logic                                in_valid,
    input  logic [frame_w(CHANNELS,WIDTH)-1:0]  in_data,
    output logic                                in_ready,
    output logic                                clk_audio,
    output logic                                sample_stb,
    output logic [frame_w(CHANNELS,WIDTH)-1:0]  out_data,
    output logic [$clog2(DEPTH):0]              fill,
    output logic [15:0]                         underrun_cnt,
    output logic [15:0]                         overrun_cnt
);
    localparam int unsigned DW    = frame_w(CHANNELS, WIDTH);
    localparam int unsigned ACC_W = acc_width(CLK_HZ);
    localparam logic [ACC_W-1:0] STEP  = ACC_W'(2 * RATE_HZ);
    localparam logic [ACC_W-1:0] LIMIT = ACC_W'(CLK_HZ);

    logic [ACC_W-1:0] acc_q, acc_d, nxt_c;
    logic             clk_audio_q, clk_audio_d;
    logic             sample_stb_q, sample_stb_d;
    logic [DW-1:0]    out_data_q, out_data_d;
    logic [15:0]      underrun_q, underrun_d;
    logic [15:0]      overrun_q, overrun_d;
    logic             tick_c, push_c, pop_c;
    logic [DW-1:0]    head_c;
    logic             full_c, empty_c;

    audio_frame_fifo #(
        .DEPTH (DEPTH),
        .DW    (DW)
    ) u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (push_c),
        .push_data (in_data),
        .pop       (pop_c),
        .head_c    (head_c),
        .fill      (fill),
        .full_c    (full_c),
        .empty_c   (empty_c)
    );

    assign in_ready     = !full_c;
    assign clk_audio    = clk_audio_q;
    assign sample_stb   = sample_stb_q;
    assign out_data     = out_data_q;
    assign underrun_cnt = underrun_q;
    assign overrun_cnt  = overrun_q;

    always_comb begin
        nxt_c       = acc_q + STEP;
        acc_d       = nxt_c;
        clk_audio_d = clk_audio_q;
        tick_c      = 1'b0;
        out_data_d  = out_data_q;
        underrun_d  = underrun_q;
        overrun_d   = overrun_q;
        // Carry out of the phase accumulator toggles the audio clock; the rising toggle is a tick.
        if (nxt_c >= LIMIT) begin
            acc_d       = nxt_c - LIMIT;
            clk_audio_d = ~clk_audio_q;
            tick_c      = ~clk_audio_q;
        end
        sample_stb_d = tick_c;
        push_c       = in_valid && !full_c;
        pop_c        = tick_c && !empty_c;
        if (tick_c) begin
            if (!empty_c) begin
                out_data_d = head_c;
            end else begin
                underrun_d = sat_inc16(underrun_q);
                if (MUTE_UNDERRUN) begin
                    out_data_d = '0;
                end
            end
        end
        if (in_valid && full_c) begin
            overrun_d = sat_inc16(overrun_q);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            acc_q        <= '0;
            clk_audio_q  <= 1'b0;
            sample_stb_q <= 1'b0;
            out_data_q   <= '0;
            underrun_q   <= '0;
            overrun_q    <= '0;
        end else begin
            acc_q        <= acc_d;
            clk_audio_q  <= clk_audio_d;
            sample_stb_q <= sample_stb_d;
            out_data_q   <= out_data_d;
            underrun_q   <= underrun_d;
            overrun_q    <= overrun_d;
        end
    end

endmodule

// File: tb/tb_hdmi_audio_pacer.sv
// Directed bench for hdmi_audio_pacer: default, muted and wide/27 MHz instances share clock and reset.
module tb_hdmi_audio_pacer;

    logic        clk = 1'b0;
    logic        resetn;
    logic        in_valid;
    logic [31:0] in_data;

    logic        in_ready, clk_audio, sample_stb;
    logic [31:0] out_data;
    logic [2:0]  fill;
    logic [15:0] underrun_cnt, overrun_cnt;

    logic        m_in_ready, m_clk_audio, m_sample_stb;
    logic [31:0] m_out_data;
    logic [2:0]  m_fill;
    logic [15:0] m_underrun_cnt, m_overrun_cnt;

    logic [191:0] w_in_data = '0;
    logic         w_in_ready, w_clk_audio, w_sample_stb;
    logic [191:0] w_out_data;
    logic [2:0]   w_fill;
    logic [15:0]  w_underrun_cnt, w_overrun_cnt;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    hdmi_audio_pacer dut (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .clk_audio(clk_audio), .sample_stb(sample_stb),
        .out_data(out_data), .fill(fill), .underrun_cnt(underrun_cnt), .overrun_cnt(overrun_cnt)
    );

    hdmi_audio_pacer #(.MUTE_UNDERRUN(1'b1)) dut_m (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_data(in_data),
        .in_ready(m_in_ready), .clk_audio(m_clk_audio), .sample_stb(m_sample_stb),
        .out_data(m_out_data), .fill(m_fill), .underrun_cnt(m_underrun_cnt), .overrun_cnt(m_overrun_cnt)
    );

    hdmi_audio_pacer #(.CLK_HZ(27000000), .CHANNELS(8), .WIDTH(24)) dut_w (
        .clk(clk), .resetn(resetn), .in_valid(1'b0), .in_data(w_in_data),
        .in_ready(w_in_ready), .clk_audio(w_clk_audio), .sample_stb(w_sample_stb),
        .out_data(w_out_data), .fill(w_fill), .underrun_cnt(w_underrun_cnt), .overrun_cnt(w_overrun_cnt)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int e);
        while (cyc < e) step();
    endtask

    // Edge (counted from reset release) of the m-th rising audio clock at 32 MHz / 48 kHz.
    function automatic int tick_edge(input int m);
        return ((2 * m - 1) * 1000 + 2) / 3;
    endfunction

    task automatic tick_at(input int m, input string tag);
        run_to(tick_edge(m));
        check(tag, sample_stb, 1'b1);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int npulse, nw, last;
        resetn   = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;

        // Reset values
        repeat (10) @(posedge clk);
        #1;
        check("rst_clk_audio", clk_audio, 0);
        check("rst_stb", sample_stb, 0);
        check("rst_out_data", out_data, 0);
        check("rst_fill", fill, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_underrun", underrun_cnt, 0);
        check("rst_overrun", overrun_cnt, 0);
        resetn = 1'b1;
        cyc    = 0;

        // Free run: tick placement, intervals and pulse counts
        npulse = 0; nw = 0; last = 0;
        while (cyc < 20000) begin
            step();
            if (cyc == 333) check("clk_audio_pre_first", clk_audio, 0);
            if (sample_stb) begin
                npulse++;
                if (npulse == 1) check("first_tick_edge", 64'(cyc), 64'd334);
                else check("tick_interval_ok", ((cyc - last) == 666) || ((cyc - last) == 667), 1'b1);
                last = cyc;
            end
            if (w_sample_stb) nw++;
        end
        check("pulses_32m", 64'(npulse), 64'd30);
        check("pulses_27m_wide", 64'(nw), 64'd36);
        check("underrun_after_freerun", underrun_cnt, 16'd30);

        // Fill to full, overflow once, then drain in order
        for (int i = 1; i <= 4; i++) begin
            in_data  = {16'(i), 16'(i)};
            in_valid = 1'b1;
            check("in_ready_push", in_ready, 1'b1);
            step();
        end
        check("fill_full", fill, 3'd4);
        check("in_ready_full", in_ready, 1'b0);
        in_data = 32'h0005_0005;
        step();
        in_valid = 1'b0;
        check("overrun_one", overrun_cnt, 16'd1);
        check("fill_after_drop", fill, 3'd4);
        for (int i = 1; i <= 4; i++) begin
            tick_at(30 + i, "drain_stb");
            check("drain_order", out_data, {16'(i), 16'(i)});
        end
        check("fill_drained", fill, 3'd0);

        // Underrun hold versus mute
        in_data  = 32'h1234_5678;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        tick_at(35, "last_frame_stb");
        check("last_frame_out", out_data, 32'h1234_5678);
        tick_at(36, "ur_stb1");
        tick_at(37, "ur_stb2");
        tick_at(38, "ur_stb3");
        check("ur_hold_out", out_data, 32'h1234_5678);
        check("ur_mute_out", m_out_data, 32'h0);
        check("ur_count", underrun_cnt, 16'd33);
        check("ur_count_mute", m_underrun_cnt, 16'd33);

        // Full FIFO with in_valid on a tick: pop happens, push refused
        for (int i = 1; i <= 4; i++) begin
            in_data  = 32'hA000_0000 + 32'(i);
            in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        run_to(tick_edge(39) - 1);
        in_data  = 32'hEEEE_EEEE;
        in_valid = 1'b1;
        check("in_ready_full_tick", in_ready, 1'b0);
        step();
        in_valid = 1'b0;
        check("full_tick_stb", sample_stb, 1'b1);
        check("full_tick_out", out_data, 32'hA000_0001);
        check("full_tick_fill", fill, 3'd3);
        check("full_tick_overrun", overrun_cnt, 16'd2);
        tick_at(40, "d_stb1");
        tick_at(41, "d_stb2");
        tick_at(42, "d_stb3");
        check("full_tick_tail", out_data, 32'hA000_0004);
        check("full_tick_drained", fill, 3'd0);

        // Push into empty FIFO on a tick: no bypass
        run_to(tick_edge(43) - 1);
        in_data  = 32'hF00D_F00D;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("empty_tick_stb", sample_stb, 1'b1);
        check("empty_tick_underrun", underrun_cnt, 16'd34);
        check("empty_tick_fill", fill, 3'd1);
        check("empty_tick_hold", out_data, 32'hA000_0004);
        tick_at(44, "next_tick_stb");
        check("next_tick_out", out_data, 32'hF00D_F00D);
        check("next_tick_fill", fill, 3'd0);

        // Asynchronous reset mid half-period with two frames buffered
        in_valid = 1'b1;
        in_data  = 32'h0BAD_0001;
        step();
        in_data  = 32'h0BAD_0002;
        step();
        in_valid = 1'b0;
        step();
        check("pre_reset_fill", fill, 3'd2);
        check("pre_reset_clk_audio", clk_audio, 1'b1);
        #2;
        resetn = 1'b0;
        #1;
        check("async_clk_audio", clk_audio, 0);
        check("async_stb", sample_stb, 0);
        check("async_out_data", out_data, 0);
        check("async_fill", fill, 0);
        check("async_in_ready", in_ready, 1);
        check("async_underrun", underrun_cnt, 0);
        check("async_overrun", overrun_cnt, 0);
        repeat (3) step();
        resetn = 1'b1;
        cyc    = 0;
        run_to(333);
        check("re_pre_clk_audio", clk_audio, 0);
        check("re_pre_stb", sample_stb, 0);
        step();
        check("re_first_clk_audio", clk_audio, 1);
        check("re_first_stb", sample_stb, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
